// File: rtl/tmr_scrub_pkg.sv
// Shared types for the TMR SRAM scrubber: FSM state encoding and default counter width.
package tmr_scrub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CHECK,
    WB
  } scrub_state_e;

  localparam int DEF_CNT_WIDTH = 32;

endpackage

// File: rtl/tmr_sram_scrubber.sv
// Background scrubber and single-port arbiter in front of the TMR SRAM wrapper.
// Walks every word, writes back the voted value on a copy disagreement, counts events.
module tmr_sram_scrubber
  import tmr_scrub_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_WORDS      = 1024,
  parameter int SCRUB_INTERVAL = 256,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  localparam int AW            = $clog2(NUM_WORDS),
  localparam int BW            = (DATA_WIDTH + 7) / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  scrub_en_i,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [AW-1:0]         host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  input  logic [BW-1:0]         host_be_i,
  output logic                  host_gnt_o,
  output logic                  host_rvalid_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [AW-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BW-1:0]         mem_be_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic [2:0]            mem_err_i,
  input  logic                  mem_uncorr_i,
  output logic [AW-1:0]         scrub_addr_o,
  output logic                  pass_done_o,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic [CNT_WIDTH-1:0]  uncorr_cnt_o
);

  // Timer only has to hold SCRUB_INTERVAL-1; keep at least one bit for an interval of 1.
  localparam int TW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  scrub_state_e          state, state_nxt;
  logic [TW-1:0]         timer;
  logic [AW-1:0]         scrub_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [CNT_WIDTH-1:0]  corr_cnt, uncorr_cnt;
  logic                  host_rvalid, pass_done;

  logic timer_hit, addr_last, wr_hazard;
  logic advance, corr_inc, uncorr_inc, latch_wb;

  assign timer_hit = scrub_en_i && (timer == TW'(SCRUB_INTERVAL - 1));
  assign addr_last = (scrub_addr == AW'(NUM_WORDS - 1));
  // A host write landing on the word being checked makes the voted copy stale.
  assign wr_hazard = host_req_i && host_we_i && (host_addr_i == scrub_addr);

  always_comb begin
    state_nxt  = state;
    advance    = 1'b0;
    corr_inc   = 1'b0;
    uncorr_inc = 1'b0;
    latch_wb   = 1'b0;
    unique case (state)
      IDLE:  if (timer_hit) state_nxt = READ;
      READ:  if (!host_req_i) state_nxt = CHECK;
      CHECK: begin
        if (mem_uncorr_i) begin
          uncorr_inc = 1'b1;
          advance    = 1'b1;
          state_nxt  = IDLE;
        end else if (|mem_err_i) begin
          if (wr_hazard) begin
            state_nxt = READ;
          end else begin
            corr_inc  = 1'b1;
            latch_wb  = 1'b1;
            state_nxt = WB;
          end
        end else begin
          advance   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WB: begin
        advance   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign host_gnt_o = host_req_i && (state != WB);

  // Port mux: write-back first, then host, then the scrub read issue.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (state == WB) begin
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = scrub_addr;
      mem_wdata_o = wb_data;
      mem_be_o    = '1;
    end else if (host_req_i) begin
      mem_req_o   = 1'b1;
      mem_we_o    = host_we_i;
      mem_addr_o  = host_addr_i;
      mem_wdata_o = host_wdata_i;
      mem_be_o    = host_be_i;
    end else if (state == READ) begin
      mem_req_o  = 1'b1;
      mem_addr_o = scrub_addr;
      mem_be_o   = '1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= IDLE;
      timer       <= '0;
      scrub_addr  <= '0;
      wb_data     <= '0;
      corr_cnt    <= '0;
      uncorr_cnt  <= '0;
      host_rvalid <= 1'b0;
      pass_done   <= 1'b0;
    end else begin
      state       <= state_nxt;
      host_rvalid <= host_gnt_o && !host_we_i;
      pass_done   <= advance && addr_last;
      if (state == IDLE && scrub_en_i && !timer_hit) timer <= timer + TW'(1);
      else                                            timer <= '0;
      if (advance)    scrub_addr <= addr_last ? '0 : scrub_addr + AW'(1);
      if (latch_wb)   wb_data    <= mem_rdata_i;
      if (corr_inc)   corr_cnt   <= sat_inc(corr_cnt);
      if (uncorr_inc) uncorr_cnt <= sat_inc(uncorr_cnt);
    end
  end

  assign host_rvalid_o = host_rvalid;
  assign host_rdata_o  = mem_rdata_i;
  assign scrub_addr_o  = scrub_addr;
  assign pass_done_o   = pass_done;
  assign corr_cnt_o    = corr_cnt;
  assign uncorr_cnt_o  = uncorr_cnt;

endmodule

// File: tb/tb_tmr_sram_scrubber.sv
// Directed/randomized bench for tmr_sram_scrubber with a behavioural SRAM + voter model.
module tb_tmr_sram_scrubber;

  localparam int DW = 64;
  localparam int NW = 16;
  localparam int AW = 4;
  localparam int BW = 8;
  localparam int SI = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni, scrub_en_i;
  logic          host_req_i, host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [DW-1:0] host_wdata_i;
  logic [BW-1:0] host_be_i;
  logic          host_gnt_o, host_rvalid_o;
  logic [DW-1:0] host_rdata_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_rdata_i;
  logic [2:0]    mem_err_i;
  logic          mem_uncorr_i;
  logic [AW-1:0] scrub_addr_o;
  logic          pass_done_o;
  logic [CW-1:0] corr_cnt_o, uncorr_cnt_o;

  tmr_sram_scrubber #(
    .DATA_WIDTH(DW), .NUM_WORDS(NW), .SCRUB_INTERVAL(SI), .CNT_WIDTH(CW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .scrub_en_i(scrub_en_i),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_be_i(host_be_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
    .mem_err_i(mem_err_i), .mem_uncorr_i(mem_uncorr_i), .scrub_addr_o(scrub_addr_o),
    .pass_done_o(pass_done_o), .corr_cnt_o(corr_cnt_o), .uncorr_cnt_o(uncorr_cnt_o)
  );

  // ---------------- behavioural SRAM + voter ----------------
  logic [31:0]   seed;
  logic          mem_load;
  logic [DW-1:0] sram [NW];
  logic          rd_pend;
  logic [AW-1:0] rd_addr;
  logic          inj_en, inj_any, inj_unc, inj_data_en, hit;
  logic [AW-1:0] inj_addr;
  logic [2:0]    inj_err;
  logic [DW-1:0] inj_data;

  function automatic logic [DW-1:0] init_word(input int i);
    return {seed ^ 32'(i * 7919), 32'h0BAD_0000 + 32'(i)};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BW-1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_load) for (int i = 0; i < NW; i++) sram[i] <= init_word(i);
    if (!rst_ni) begin
      rd_pend <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_pend <= mem_req_o && !mem_we_o;
      rd_addr <= mem_addr_o;
    end
    if (mem_req_o && mem_we_o)
      for (int b = 0; b < BW; b++)
        if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
  end

  always_comb begin
    hit          = 1'b0;
    mem_rdata_i  = '0;
    mem_err_i    = '0;
    mem_uncorr_i = 1'b0;
    if (rd_pend) begin
      hit         = inj_en && (inj_any || rd_addr == inj_addr);
      mem_rdata_i = (hit && inj_data_en) ? inj_data : sram[rd_addr];
      if (hit) begin
        mem_err_i    = inj_err;
        mem_uncorr_i = inj_unc;
      end
    end
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  int n_swr = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (mem_req_o && mem_we_o && !host_gnt_o) n_swr <= n_swr + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_membus"}, 64'({mem_req_o, mem_we_o, mem_addr_o, mem_be_o}), 64'd0);
    chk({tag, "_wdata"}, mem_wdata_o, 64'd0);
    chk({tag, "_host"}, 64'({host_gnt_o, host_rvalid_o}), 64'd0);
    chk({tag, "_rdata"}, host_rdata_o, 64'd0);
    chk({tag, "_scrub"}, 64'({scrub_addr_o, pass_done_o, corr_cnt_o, uncorr_cnt_o}), 64'd0);
  endtask

  // Returns at the negedge of the cycle holding the matching scrub access.
  task automatic wait_scrub(input string tag, input bit wr, input int want, input int budget,
                            output int c);
    bit found;
    found = 1'b0;
    c = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (mem_req_o && !host_gnt_o && (mem_we_o == wr) &&
          (want < 0 || int'(mem_addr_o) == want)) begin
        found = 1'b1;
        c = cyc;
        break;
      end
      step();
    end
    chk({tag, "_seen"}, 64'(found), 64'd1);
  endtask

  task automatic count_reads(input int n, output int nrd);
    nrd = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (mem_req_o && !mem_we_o && !host_gnt_o) nrd++;
      step();
    end
  endtask

  // ---------------- stimulus ----------------
  logic [DW-1:0] ref_mem [NW];
  int            rd_cyc [17];
  int            rd_adr [17];

  initial begin
    int c, t, w, r, n_rd, n_pd, pd_cyc, swr0, nrd, prev, bad_gnt, bad_mux, bad_rd;
    logic [DW-1:0] d, exp_d;
    logic [BW-1:0] be;
    logic [AW-1:0] a1, ha;

    seed = $urandom;
    mem_load = 1'b1;
    rst_ni = 1'b0; scrub_en_i = 1'b0;
    host_req_i = 1'b0; host_we_i = 1'b0; host_addr_i = '0; host_wdata_i = '0; host_be_i = '0;
    inj_en = 1'b0; inj_any = 1'b0; inj_unc = 1'b0; inj_data_en = 1'b0;
    inj_addr = '0; inj_err = '0; inj_data = '0;
    repeat (3) step();
    mem_load = 1'b0;
    for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
    @(negedge clk);
    chk_zero("reset");

    // 1: clean pass, one read every SI+2 cycles, wrap pulse after address 15
    step();
    rst_ni = 1'b1; scrub_en_i = 1'b1;
    swr0 = n_swr; n_rd = 0; n_pd = 0; pd_cyc = -1;
    for (int k = 0; k < 200 && n_rd < 17; k++) begin
      @(negedge clk);
      if (pass_done_o) begin n_pd++; pd_cyc = cyc; end
      if (mem_req_o && !mem_we_o && !host_gnt_o) begin
        rd_cyc[n_rd] = cyc; rd_adr[n_rd] = int'(mem_addr_o); n_rd++;
      end
      step();
    end
    scrub_en_i = 1'b0;
    chk("t1_nreads", 64'(n_rd), 64'd17);
    for (int i = 0; i < 17; i++) chk($sformatf("t1_addr%0d", i), 64'(rd_adr[i]), 64'(i % NW));
    for (int i = 1; i < 17; i++)
      chk($sformatf("t1_period%0d", i), 64'(rd_cyc[i] - rd_cyc[i-1]), 64'(SI + 2));
    chk("t1_pass_cnt", 64'(n_pd), 64'd1);
    chk("t1_pass_cyc", 64'(pd_cyc), 64'(rd_cyc[15] + 2));
    count_reads(10, nrd);
    chk("t1_hold_idle", 64'(nrd), 64'd0);
    @(negedge clk);
    chk("t1_addr_after", 64'(scrub_addr_o), 64'd1);
    chk("t1_cnts", 64'({corr_cnt_o, uncorr_cnt_o}), 64'd0);
    chk("t1_nowrites", 64'(n_swr - swr0), 64'd0);

    // 2: correctable error at addr 3 with a given voted word
    step();
    scrub_en_i = 1'b1;
    inj_en = 1'b1; inj_addr = 4'd3; inj_err = 3'b001; inj_unc = 1'b0;
    inj_data_en = 1'b1; inj_data = 64'hA5A5_0000_0000_5A5A;
    wait_scrub("t2_rd", 1'b0, 3, 60, t);
    step();
    wait_scrub("t2_wb", 1'b1, -1, 10, w);
    chk("t2_wb_cyc", 64'(w), 64'(t + 2));
    chk("t2_wb_addr", 64'(mem_addr_o), 64'd3);
    chk("t2_wb_be", 64'(mem_be_o), 64'hFF);
    chk("t2_wb_data", mem_wdata_o, 64'hA5A5_0000_0000_5A5A);
    chk("t2_corr", 64'(corr_cnt_o), 64'd1);
    inj_en = 1'b0; inj_data_en = 1'b0;
    ref_mem[3] = 64'hA5A5_0000_0000_5A5A;

    // 3: uncorrectable at addr 7
    inj_en = 1'b1; inj_addr = 4'd7; inj_unc = 1'b1; inj_err = 3'($urandom_range(1, 7));
    wait_scrub("t3_rd", 1'b0, 7, 60, t);
    step();
    @(negedge clk);
    chk("t3_check_idle", 64'(mem_req_o), 64'd0);
    step();
    @(negedge clk);
    chk("t3_no_wb", 64'(mem_req_o), 64'd0);
    chk("t3_addr", 64'(scrub_addr_o), 64'd8);
    chk("t3_uncorr", 64'(uncorr_cnt_o), 64'd1);
    chk("t3_corr", 64'(corr_cnt_o), 64'd1);
    inj_en = 1'b0; inj_unc = 1'b0;

    // 4: host write hits the checked word -> re-read, count only once
    inj_en = 1'b1; inj_addr = 4'd9; inj_err = 3'($urandom_range(1, 7));
    wait_scrub("t4_rd", 1'b0, 9, 40, t);
    step();
    d = {$urandom, $urandom};
    be = 8'($urandom_range(1, 255));
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 4'd9; host_wdata_i = d; host_be_i = be;
    @(negedge clk);
    chk("t4_host_gnt", 64'(host_gnt_o), 64'd1);
    chk("t4_host_bus", 64'({mem_req_o, mem_we_o, mem_addr_o}), 64'({1'b1, 1'b1, 4'd9}));
    step();
    host_req_i = 1'b0; host_we_i = 1'b0;
    @(negedge clk);
    chk("t4_reread", 64'({mem_req_o, mem_we_o, mem_addr_o}), 64'({1'b1, 1'b0, 4'd9}));
    chk("t4_corr_hold", 64'(corr_cnt_o), 64'd1);
    exp_d = merge(ref_mem[9], d, be);
    step();
    wait_scrub("t4_wb", 1'b1, -1, 10, w);
    chk("t4_wb_cyc", 64'(w), 64'(t + 4));
    chk("t4_wb_addr", 64'(mem_addr_o), 64'd9);
    chk("t4_wb_data", mem_wdata_o, exp_d);
    chk("t4_corr", 64'(corr_cnt_o), 64'd2);
    ref_mem[9] = exp_d;
    inj_en = 1'b0;

    // 5a: host holds the port through READ for 10 cycles
    wait_scrub("t5_rd10", 1'b0, 10, 40, t);
    repeat (6) step();
    bad_gnt = 0; bad_mux = 0; bad_rd = 0; prev = 0;
    for (int k = 0; k < 10; k++) begin
      ha = 4'($urandom_range(0, NW - 1));
      host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = ha;
      @(negedge clk);
      if (host_gnt_o !== 1'b1) bad_gnt++;
      if (mem_we_o !== 1'b0 || mem_addr_o !== ha) bad_mux++;
      if (k > 0 && (host_rvalid_o !== 1'b1 || host_rdata_o !== ref_mem[prev])) bad_rd++;
      prev = int'(ha);
      step();
    end
    host_req_i = 1'b0;
    @(negedge clk);
    chk("t5_hold_gnt", 64'(bad_gnt), 64'd0);
    chk("t5_hold_mux", 64'(bad_mux), 64'd0);
    chk("t5_hold_rd", 64'(bad_rd), 64'd0);
    chk("t5_last_rdata", host_rdata_o, ref_mem[prev]);
    chk("t5_release_rd", 64'({mem_req_o, mem_we_o, mem_addr_o}), 64'({1'b1, 1'b0, 4'd11}));

    // 5b: host request during write-back loses for exactly that cycle
    inj_en = 1'b1; inj_addr = 4'd12; inj_err = 3'($urandom_range(1, 7));
    step();
    wait_scrub("t5_rd12", 1'b0, 12, 20, t);
    step();
    a1 = 4'($urandom_range(0, NW - 1));
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = a1;
    @(negedge clk);
    chk("t5_gnt_check", 64'(host_gnt_o), 64'd1);
    step();
    host_addr_i = 4'($urandom_range(0, NW - 1));
    @(negedge clk);
    chk("t5_gnt_wb", 64'(host_gnt_o), 64'd0);
    chk("t5_wb_bus", 64'({mem_req_o, mem_we_o, mem_addr_o, mem_be_o}),
        64'({1'b1, 1'b1, 4'd12, 8'hFF}));
    chk("t5_wb_data", mem_wdata_o, ref_mem[12]);
    chk("t5_host_rd", 64'(host_rvalid_o), 64'd1);
    chk("t5_host_rdata", host_rdata_o, ref_mem[a1]);
    chk("t5_corr", 64'(corr_cnt_o), 64'd3);
    step();
    @(negedge clk);
    chk("t5_gnt_after", 64'(host_gnt_o), 64'd1);
    step();
    host_req_i = 1'b0;
    inj_en = 1'b0;

    // 6: saturation, then reset in the middle of a write-back
    inj_en = 1'b1; inj_any = 1'b1; inj_unc = 1'b0; inj_err = 3'($urandom_range(1, 7));
    for (int i = 0; i < 13; i++) begin
      wait_scrub($sformatf("t6_wb%0d", i), 1'b1, -1, 40, w);
      if (i == 11) chk("t6_corr_sat", 64'(corr_cnt_o), 64'd15);
      if (i == 12) chk("t6_corr_hold", 64'(corr_cnt_o), 64'd15);
      if (i < 12) step();
    end
    rst_ni = 1'b0;
    step();
    @(negedge clk);
    chk_zero("t6_rst_wb");
    swr0 = n_swr;
    step();
    rst_ni = 1'b1;
    inj_en = 1'b0; inj_any = 1'b0;
    r = cyc;
    wait_scrub("t6_first_rd", 1'b0, -1, 20, c);
    chk("t6_first_cyc", 64'(c), 64'(r + SI));
    chk("t6_first_addr", 64'(mem_addr_o), 64'd0);
    chk("t6_no_stale_wb", 64'(n_swr - swr0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tmr_sram_scrubber.md
# tmr_sram_scrubber

Background scrubber and port arbiter that sits directly upstream of the triple-redundant SRAM wrapper. It shares the single SRAM port between the host (cache/controller) and an internal scrub engine. The scrub engine periodically walks every word, checks the voter's per-copy disagreement flags, and writes the voted value back so that a corrupted copy is repaired before a second copy fails. It also keeps saturating corrected and uncorrectable event counters.

## Interface
Parameters:
- DATA_WIDTH, 64, word width; matches the downstream SRAM.
- NUM_WORDS, 1024, memory depth; AW = $clog2(NUM_WORDS).
- SCRUB_INTERVAL, 256, idle cycles between scrub reads; legal range ≥ 1.
- CNT_WIDTH, 32, width of the event counters.

Ports (one clock, `clk_i`; reset `rst_ni` is synchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- scrub_en_i  in  1  enables the scrub engine
- host_req_i / host_we_i  in  1 / 1  host request / write
- host_addr_i  in  AW  host address
- host_wdata_i  in  DATA_WIDTH  host write data
- host_be_i  in  (DATA_WIDTH+7)/8  host byte enables
- host_gnt_o  out  1  host request accepted this cycle
- host_rvalid_o  out  1  host read data valid
- host_rdata_o  out  DATA_WIDTH  host read data
- mem_req_o / mem_we_o  out  1 / 1  SRAM request / write
- mem_addr_o, mem_wdata_o, mem_be_o  out  AW, DATA_WIDTH, BE  SRAM command
- mem_rdata_i  in  DATA_WIDTH  voted SRAM read data
- mem_err_i  in  3  per-copy disagreement flags from the voter, valid with mem_rdata_i
- mem_uncorr_i  in  1  no majority exists, valid with mem_rdata_i
- scrub_addr_o  out  AW  next address to scrub
- pass_done_o  out  1  one-cycle pulse when the scrub address wraps
- corr_cnt_o, uncorr_cnt_o  out  CNT_WIDTH  saturating event counters

## Operation
- States: IDLE, READ, CHECK, WB.
- IDLE:
  - The interval timer counts up while scrub_en_i=1 and is held at 0 otherwise.
  - When the timer reaches SCRUB_INTERVAL-1, the timer clears and the FSM goes to READ.
- READ:
  - If host_req_i=1, the host owns the port and the FSM stays in READ.
  - Otherwise the engine issues a read of scrub_addr and goes to CHECK.
- CHECK: mem_rdata_i, mem_err_i and mem_uncorr_i belong to the scrub read and are evaluated:
  - mem_uncorr_i=1: uncorr_cnt +1, no write-back, address advances, go to IDLE.
  - mem_err_i≠0 and mem_uncorr_i=0: latch mem_rdata_i, corr_cnt +1, go to WB.
  - mem_err_i=0: address advances, go to IDLE.
  - Hazard: a host write granted in CHECK to scrub_addr voids the latched data. No count, no advance; go straight back to READ for the same address.
- WB:
  - Write the latched data to scrub_addr with all byte enables set; the port is not preemptible.
  - Address advances, go to IDLE.
- Address advance: scrub_addr wraps from NUM_WORDS-1 to 0, and pass_done_o pulses in the cycle after the wrap.
- Counters saturate at all-ones and never wrap.
- scrub_en_i deasserted mid-scrub: the in-flight CHECK/WB completes, then the FSM enters IDLE and holds there.
- Host-side mem_err_i/mem_uncorr_i are ignored; only scrub reads are counted or corrected.
- Priority:
  - WB beats the host.
  - The host beats the READ issue.
  - Sustained host traffic may starve scrubbing indefinitely; this is accepted.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE, the timer is 0, scrub_addr is 0.
  - The latched write-back data is 0.
- host_gnt_o = host_req_i && state≠WB (combinational).
- mem_* outputs are driven combinationally from the winning requester.
- SRAM read latency is 1 cycle:
  - host_rvalid_o is asserted the cycle after a granted host read.
  - host_rdata_o = mem_rdata_i, passed through.
- Scrub with no error: read at t, CHECK at t+1, IDLE at t+2.
- Scrub with a correctable error: read at t, CHECK at t+1, write at t+2, IDLE at t+3.
- Counters and scrub_addr update on the clock edge that leaves CHECK or WB.
- Minimum period between scrub reads with no host traffic is SCRUB_INTERVAL+2 cycles.
- Reset asserted mid-operation (including during WB) aborts immediately. A write in progress at the reset edge is not issued afterwards.

## Structure
- Shared package `tmr_scrub_pkg`: the `scrub_state_e` enum (IDLE/READ/CHECK/WB) and the default CNT_WIDTH constant.
- Single module with no sub-modules. The saturating counter is a local function, not a separate block.
- The existing TMR SRAM wrapper instantiates downstream; its voter drives mem_err_i/mem_uncorr_i.

## Test plan
All scenarios use NUM_WORDS=16, SCRUB_INTERVAL=4.
1. Idle, clean memory, scrub_en_i=1 → one read every 6 cycles; addresses 0..15; pass_done_o pulses after address 15; both counters stay 0.
2. Voter flags mem_err_i=3'b001 with voted data 0xA5A5_0000_0000_5A5A at addr 3 → write to addr 3 with be=0xFF and that data at CHECK+1; corr_cnt=1.
3. mem_uncorr_i=1 at addr 7 → no write; uncorr_cnt=1; scrub_addr=8.
4. Host write to the scrub address in the CHECK cycle of an errored read → no WB; the same address is re-read on the next READ; corr_cnt increments only on the re-read.
5. Host req held high through READ for 10 cycles → host_gnt_o=1 throughout; no scrub read issued; the scrub read issues the cycle host_req_i drops. Host req during WB → host_gnt_o=0 for exactly that cycle.
6. Force corr_cnt to all-ones, then inject an error → corr_cnt holds all-ones. Reset asserted during WB → all outputs 0 next cycle and no write issued.
